// File: rtl/persp_pkg.sv
// persp_pkg: shared definitions for the perspective-divide / viewport stage.
//   state_t       FSM state encoding for persp_viewport
//   PV_FRAC, ONE  default fractional bit count and fixed-point 1.0
//   COMP_*        component offsets inside the packed vertex buses
//   sat_signed    clamp a 64-bit signed value into a signed w-bit range
package persp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_DIV,
    S_SCALE,
    S_VIEW,
    S_EMIT
  } state_t;

  localparam int PV_FRAC = 12;
  localparam logic signed [63:0] ONE = 64'sd1 <<< PV_FRAC;

  // Input vertices carry x,y,z,w; output vertices carry sx,sy,sz.
  localparam int COMP_X    = 0;
  localparam int COMP_Y    = 1;
  localparam int COMP_Z    = 2;
  localparam int COMP_W    = 3;
  localparam int IN_COMPS  = 4;
  localparam int OUT_COMPS = 3;

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      sat_signed = hi;
    else if (v < lo) sat_signed = lo;
    else             sat_signed = v;
  endfunction

endpackage

// File: rtl/recip_div.sv
// recip_div: restoring divider computing floor(2^(WIDTH)/w) one quotient bit
// per cycle, i.e. the 1/w reciprocal in 12.12 when WIDTH = 2*FRAC.
//   start_i      load w_i and begin (latency is always WIDTH+1 cycles)
//   w_i          positive divisor
//   busy_o       a division is in progress
//   done_o       high during the final step; quotient_o is final after it
//   quotient_o   low WIDTH bits of the quotient
//   saturated_o  quotient does not fit a signed WIDTH value
module recip_div #(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] w_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic             saturated_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH:0]   quo_q, quo_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH:0]   trial;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    den_d  = den_q;
    // The dividend is a single 1 at bit WIDTH, so only the first step
    // shifts in a one.
    trial  = {rem_q[WIDTH-1:0], (cnt_q == '0)};
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = '0;
      den_d  = w_i;
    end else if (busy_q) begin
      if (trial >= {1'b0, den_q}) begin
        rem_d = trial - {1'b0, den_q};
        quo_d = {quo_q[WIDTH-1:0], 1'b1};
      end else begin
        rem_d = trial;
        quo_d = {quo_q[WIDTH-1:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    den_q <= den_d;
  end

  assign busy_o      = busy_q;
  assign done_o      = busy_q && (cnt_q == CW'(WIDTH));
  assign quotient_o  = quo_q[WIDTH-1:0];
  assign saturated_o = quo_q[WIDTH] | quo_q[WIDTH-1];

endmodule

// File: rtl/persp_viewport.sv
// persp_viewport: takes a clipped batch of 0..2 triangles (6 homogeneous
// 12.12 vertices), divides each vertex by w, applies the viewport transform
// and emits screen-space triangles one at a time.
//   clk_i, reset_i            clock, async active-high reset
//   tri_valid_i/tri_ready_o   batch handshake (ready only in IDLE)
//   num_triangles_i, verts_i  batch contents, vp_* viewport (all latched)
//   out_valid_o/out_ready_i   triangle handshake
//   out_vert_o, out_last_o    screen vertices and last-of-batch flag
// Optional macro PERSP_VIEWPORT_STATS_EN adds stat_emitted_o/stat_culled_o.
module persp_viewport
  import persp_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int FRAC  = PV_FRAC
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 tri_valid_i,
  output logic                 tri_ready_o,
  input  logic [1:0]           num_triangles_i,
  input  logic [24*WIDTH-1:0]  verts_i,
  input  logic [WIDTH-1:0]     vp_x0_i,
  input  logic [WIDTH-1:0]     vp_y0_i,
  input  logic [WIDTH-1:0]     vp_half_w_i,
  input  logic [WIDTH-1:0]     vp_half_h_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [9*WIDTH-1:0]   out_vert_o,
`ifdef PERSP_VIEWPORT_STATS_EN
  output logic [31:0]          stat_emitted_o,
  output logic [31:0]          stat_culled_o,
`endif
  output logic                 out_last_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic signed [63:0] ONE_F = 64'sd1 <<< FRAC;
  localparam logic [WIDTH-1:0] R_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  function automatic logic signed [63:0] sx64(input logic [WIDTH-1:0] v);
    sx64 = {{(64-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  state_t state_q, state_d;
  logic [2:0]   vtx_q, vtx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]   num_q, num_d;
  logic vtx_bad_q, vtx_bad_d, tri_bad_q, tri_bad_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [9*WIDTH-1:0] out_vert_q, out_vert_d;
`ifdef PERSP_VIEWPORT_STATS_EN
  logic [31:0] emitted_q, emitted_d, culled_q, culled_d;
`endif

  logic [24*WIDTH-1:0] verts_q, verts_d;
  logic [WIDTH-1:0] vpx0_q, vpx0_d, vpy0_q, vpy0_d, vphw_q, vphw_d, vphh_q, vphh_d;
  logic [WIDTH-1:0] ndc_x_q, ndc_x_d, ndc_y_q, ndc_y_d, ndc_z_q, ndc_z_d;

  logic [2:0] corner;
  int         vi, oi;
  logic signed [WIDTH-1:0] cur_x, cur_y, cur_z, cur_w;
  logic [WIDTH-1:0] recip;
  logic signed [63:0] ndc_x_w, ndc_y_w, ndc_z_w, sx_w, sy_w, sz_w;
  logic num_ok, w_bad, more_tri;
  logic div_start, div_busy, div_done, div_sat;
  logic [WIDTH-1:0] div_quo;

  recip_div #(.WIDTH(WIDTH)) u_div (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (div_start),
    .w_i         (cur_w),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .saturated_o (div_sat)
  );

  // Arithmetic for the current vertex; selected by vtx_q.
  always_comb begin
    corner  = (vtx_q >= 3'd3) ? (vtx_q - 3'd3) : vtx_q;
    vi      = int'(vtx_q);
    oi      = int'(corner);
    cur_x   = verts_q[(IN_COMPS*vi + COMP_X)*WIDTH +: WIDTH];
    cur_y   = verts_q[(IN_COMPS*vi + COMP_Y)*WIDTH +: WIDTH];
    cur_z   = verts_q[(IN_COMPS*vi + COMP_Z)*WIDTH +: WIDTH];
    cur_w   = verts_q[(IN_COMPS*vi + COMP_W)*WIDTH +: WIDTH];
    w_bad   = (cur_w <= 0);
    recip   = vtx_bad_q ? '0 : (div_sat ? R_MAX : div_quo);
    ndc_x_w = sat_signed((sx64(cur_x) * sx64(recip)) >>> FRAC, WIDTH);
    ndc_y_w = sat_signed((sx64(cur_y) * sx64(recip)) >>> FRAC, WIDTH);
    ndc_z_w = sat_signed((sx64(cur_z) * sx64(recip)) >>> FRAC, WIDTH);
    sx_w    = sat_signed(sx64(vpx0_q) +
                         (((sx64(ndc_x_q) + ONE_F) * sx64(vphw_q)) >>> FRAC), WIDTH);
    // Screen Y grows downward, so NDC y is flipped.
    sy_w    = sat_signed(sx64(vpy0_q) +
                         (((ONE_F - sx64(ndc_y_q)) * sx64(vphh_q)) >>> FRAC), WIDTH);
    sz_w    = sat_signed((sx64(ndc_z_q) + ONE_F) >>> 1, WIDTH);
  end

  always_comb begin
    state_d     = state_q;
    vtx_d       = vtx_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    vtx_bad_d   = vtx_bad_q;
    tri_bad_d   = tri_bad_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_vert_d  = out_vert_q;
    verts_d     = verts_q;
    vpx0_d      = vpx0_q;
    vpy0_d      = vpy0_q;
    vphw_d      = vphw_q;
    vphh_d      = vphh_q;
    ndc_x_d     = ndc_x_q;
    ndc_y_d     = ndc_y_q;
    ndc_z_d     = ndc_z_q;
    div_start   = 1'b0;
`ifdef PERSP_VIEWPORT_STATS_EN
    emitted_d   = emitted_q;
    culled_d    = culled_q;
`endif
    num_ok   = (num_q == 2'd1) || (num_q == 2'd2);
    more_tri = (vtx_q == 3'd2) && (num_q == 2'd2);

    case (state_q)
      S_IDLE: begin
        if (tri_valid_i) begin
          verts_d = verts_i;
          num_d   = num_triangles_i;
          vpx0_d  = vp_x0_i;
          vpy0_d  = vp_y0_i;
          vphw_d  = vp_half_w_i;
          vphh_d  = vp_half_h_i;
          vtx_d   = 3'd0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!num_ok) begin
          state_d = S_IDLE;
`ifdef PERSP_VIEWPORT_STATS_EN
          if (num_q == 2'd3) culled_d = culled_q + 32'd1;
`endif
        end else begin
          vtx_bad_d = w_bad;
          tri_bad_d = (corner == 3'd0) ? w_bad : (tri_bad_q | w_bad);
          div_start = !w_bad && !div_busy;
          cnt_d     = '0;
          state_d   = S_DIV;
        end
      end
      S_DIV: begin
        // A skipped divide still burns the same WIDTH+1 cycles.
        cnt_d = cnt_q + 1'b1;
        if (vtx_bad_q ? (cnt_q == CW'(WIDTH)) : div_done) state_d = S_SCALE;
      end
      S_SCALE: begin
        ndc_x_d = ndc_x_w[WIDTH-1:0];
        ndc_y_d = ndc_y_w[WIDTH-1:0];
        ndc_z_d = ndc_z_w[WIDTH-1:0];
        state_d = S_VIEW;
      end
      S_VIEW: begin
        out_vert_d[(OUT_COMPS*oi + COMP_X)*WIDTH +: WIDTH] = sx_w[WIDTH-1:0];
        out_vert_d[(OUT_COMPS*oi + COMP_Y)*WIDTH +: WIDTH] = sy_w[WIDTH-1:0];
        out_vert_d[(OUT_COMPS*oi + COMP_Z)*WIDTH +: WIDTH] = sz_w[WIDTH-1:0];
        if (corner != 3'd2) begin
          vtx_d   = vtx_q + 3'd1;
          state_d = S_SETUP;
        end else if (tri_bad_q) begin
          // Culled triangle: behave as if it had been handshaken.
`ifdef PERSP_VIEWPORT_STATS_EN
          culled_d = culled_q + 32'd1;
`endif
          vtx_d   = more_tri ? 3'd3 : vtx_q;
          state_d = more_tri ? S_SETUP : S_IDLE;
        end else begin
          out_valid_d = 1'b1;
          out_last_d  = (vtx_q == 3'd5) || (num_q == 2'd1);
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
`ifdef PERSP_VIEWPORT_STATS_EN
          emitted_d   = emitted_q + 32'd1;
`endif
          vtx_d   = more_tri ? 3'd3 : vtx_q;
          state_d = more_tri ? S_SETUP : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      vtx_q       <= '0;
      cnt_q       <= '0;
      num_q       <= '0;
      vtx_bad_q   <= 1'b0;
      tri_bad_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_vert_q  <= '0;
`ifdef PERSP_VIEWPORT_STATS_EN
      emitted_q   <= '0;
      culled_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vtx_q       <= vtx_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      vtx_bad_q   <= vtx_bad_d;
      tri_bad_q   <= tri_bad_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_vert_q  <= out_vert_d;
`ifdef PERSP_VIEWPORT_STATS_EN
      emitted_q   <= emitted_d;
      culled_q    <= culled_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    verts_q <= verts_d;
    vpx0_q  <= vpx0_d;
    vpy0_q  <= vpy0_d;
    vphw_q  <= vphw_d;
    vphh_q  <= vphh_d;
    ndc_x_q <= ndc_x_d;
    ndc_y_q <= ndc_y_d;
    ndc_z_q <= ndc_z_d;
  end

  assign tri_ready_o = (state_q == S_IDLE);
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_vert_o  = out_vert_q;
`ifdef PERSP_VIEWPORT_STATS_EN
  assign stat_emitted_o = emitted_q;
  assign stat_culled_o  = culled_q;
`endif

endmodule

// File: tb/tb_persp_viewport.sv
// tb_persp_viewport: directed bench for persp_viewport covering reset,
// single and double triangle batches, back-pressure, culling, mid-divide
// reset and dropped batches.
module tb_persp_viewport;
  localparam int W = 24;

  logic clk = 1'b0;
  logic reset_i;
  logic tri_valid_i;
  logic tri_ready_o;
  logic [1:0] num_triangles_i;
  logic [24*W-1:0] verts_i;
  logic [W-1:0] vp_x0_i, vp_y0_i, vp_half_w_i, vp_half_h_i;
  logic out_valid_o, out_ready_i, out_last_o;
  logic [9*W-1:0] out_vert_o;
`ifdef PERSP_VIEWPORT_STATS_EN
  logic [31:0] stat_emitted_o, stat_culled_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  persp_viewport #(.WIDTH(W), .FRAC(12)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .tri_valid_i     (tri_valid_i),
    .tri_ready_o     (tri_ready_o),
    .num_triangles_i (num_triangles_i),
    .verts_i         (verts_i),
    .vp_x0_i         (vp_x0_i),
    .vp_y0_i         (vp_y0_i),
    .vp_half_w_i     (vp_half_w_i),
    .vp_half_h_i     (vp_half_h_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_vert_o      (out_vert_o),
`ifdef PERSP_VIEWPORT_STATS_EN
    .stat_emitted_o  (stat_emitted_o),
    .stat_culled_o   (stat_culled_o),
`endif
    .out_last_o      (out_last_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vert(input int k, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] z, input logic [W-1:0] w);
    verts_i[(4*k+0)*W +: W] = x;
    verts_i[(4*k+1)*W +: W] = y;
    verts_i[(4*k+2)*W +: W] = z;
    verts_i[(4*k+3)*W +: W] = w;
  endtask

  task automatic set_vp(input logic [W-1:0] x0, input logic [W-1:0] y0,
                        input logic [W-1:0] hw, input logic [W-1:0] hh);
    vp_x0_i = x0; vp_y0_i = y0; vp_half_w_i = hw; vp_half_h_i = hh;
  endtask

  task automatic set_basic_tri(input int base);
    set_vert(base + 0, 24'h000800, 24'h000800, 24'h000000, 24'h001000);
    set_vert(base + 1, 24'h000000, 24'h000000, 24'h000000, 24'h001000);
    set_vert(base + 2, 24'hFFF000, 24'hFFF000, 24'h001000, 24'h001000);
  endtask

  // Present a batch for one edge, then scramble the inputs so the DUT must
  // work from its latched copy.
  task automatic accept(input logic [1:0] n);
    num_triangles_i = n;
    tri_valid_i = 1'b1;
    tick();
    tri_valid_i = 1'b0;
    num_triangles_i = 2'($urandom);
    for (int i = 0; i < 24; i++) verts_i[i*W +: W] = W'($urandom);
    set_vp(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid_o !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tri_valid_i = 1'b0;
    out_ready_i = 1'b0;
    num_triangles_i = '0;
    verts_i = '0;
    set_vp('0, '0, '0, '0);
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    checks++; if (tri_ready_o !== 1'b1) begin errors++; $display("FAIL reset_tri_ready got %b want 1", tri_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
    checks++; if (out_last_o !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last_o); end
    checks++; if (out_vert_o !== '0) begin errors++; $display("FAIL reset_out_vert got %h want 0", out_vert_o); end
  endtask

  task automatic test_single();
    logic [W-1:0] exp [9];
    int n;
    exp = '{24'h1E0000, 24'h078000, 24'h000800,
            24'h140000, 24'h0F0000, 24'h000800,
            24'h000000, 24'h1E0000, 24'h001000};
    set_vp(24'h000000, 24'h000000, 24'h140000, 24'h0F0000);
    verts_i = '0;
    set_basic_tri(0);
    accept(2'd1);
    checks++; if (tri_ready_o !== 1'b0) begin errors++; $display("FAIL single_busy_ready got %b want 0", tri_ready_o); end
    wait_valid(n);
    checks++; if (n != 84) begin errors++; $display("FAIL single_latency got %0d want 84", n); end
    checks++; if (out_last_o !== 1'b1) begin errors++; $display("FAIL single_last got %b want 1", out_last_o); end
    for (int j = 0; j < 9; j++) begin
      checks++;
      if (out_vert_o[j*W +: W] !== exp[j]) begin
        errors++; $display("FAIL single_vert[%0d] got %h want %h", j, out_vert_o[j*W +: W], exp[j]);
      end
    end
    handshake();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b want 0", out_valid_o); end
    checks++; if (tri_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready_back got %b want 1", tri_ready_o); end
  endtask

  task automatic test_persp();
    int n;
    set_vp(24'h000000, 24'h000000, 24'h140000, 24'h0F0000);
    verts_i = '0;
    set_basic_tri(0);
    set_vert(0, 24'h001000, 24'h001000, 24'h000000, 24'h002000);
    accept(2'd1);
    wait_valid(n);
    checks++; if (n != 84) begin errors++; $display("FAIL persp_latency got %0d want 84", n); end
    checks++; if (out_vert_o[0*W +: W] !== 24'h1E0000) begin errors++; $display("FAIL persp_sx got %h want 1e0000", out_vert_o[0*W +: W]); end
    checks++; if (out_vert_o[1*W +: W] !== 24'h078000) begin errors++; $display("FAIL persp_sy got %h want 078000", out_vert_o[1*W +: W]); end
    checks++; if (out_vert_o[2*W +: W] !== 24'h000800) begin errors++; $display("FAIL persp_sz got %h want 000800", out_vert_o[2*W +: W]); end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp1 [9];
    logic [W-1:0] exp2 [9];
    logic [9*W-1:0] snap;
    int n;
    // Viewport origin (16.0, 8.0) shifts every sx/sy.
    exp1 = '{24'h1F0000, 24'h080000, 24'h000800,
             24'h150000, 24'h0F8000, 24'h000800,
             24'h010000, 24'h1E8000, 24'h001000};
    // Middle vertex has w = 1 ulp: reciprocal and sx saturate.
    exp2 = '{24'h3D0000, 24'h0F8000, 24'h000800,
             24'h7FFFFF, 24'h0F8000, 24'h4007FF,
             24'h150000, 24'h0F8000, 24'h000800};
    set_vp(24'h010000, 24'h008000, 24'h140000, 24'h0F0000);
    set_basic_tri(0);
    set_vert(3, 24'h002000, 24'h000000, 24'h000000, 24'h001000);
    set_vert(4, 24'h001000, 24'h000000, 24'h001000, 24'h000001);
    set_vert(5, 24'h000000, 24'h000000, 24'h000000, 24'h001000);
    accept(2'd2);
    wait_valid(n);
    checks++; if (n != 84) begin errors++; $display("FAIL b2b_latency1 got %0d want 84", n); end
    checks++; if (out_last_o !== 1'b0) begin errors++; $display("FAIL b2b_last1 got %b want 0", out_last_o); end
    for (int j = 0; j < 9; j++) begin
      checks++;
      if (out_vert_o[j*W +: W] !== exp1[j]) begin
        errors++; $display("FAIL b2b_tri1[%0d] got %h want %h", j, out_vert_o[j*W +: W], exp1[j]);
      end
    end
    snap = out_vert_o;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (out_valid_o !== 1'b1 || out_vert_o !== snap || out_last_o !== 1'b0) begin
        errors++; $display("FAIL b2b_stall cyc%0d valid %b last %b vert %h want 1 0 %h",
                           c, out_valid_o, out_last_o, out_vert_o, snap);
      end
    end
    handshake();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b want 0", out_valid_o); end
    wait_valid(n);
    checks++; if (n != 84) begin errors++; $display("FAIL b2b_latency2 got %0d want 84", n); end
    checks++; if (out_last_o !== 1'b1) begin errors++; $display("FAIL b2b_last2 got %b want 1", out_last_o); end
    for (int j = 0; j < 9; j++) begin
      checks++;
      if (out_vert_o[j*W +: W] !== exp2[j]) begin
        errors++; $display("FAIL b2b_tri2[%0d] got %h want %h", j, out_vert_o[j*W +: W], exp2[j]);
      end
    end
    handshake();
    checks++; if (tri_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_back got %b want 1", tri_ready_o); end
  endtask

  task automatic test_bad_w();
    int n;
    bit saw_valid;
    set_vp(24'h000000, 24'h000000, 24'h140000, 24'h0F0000);
    set_basic_tri(0);
    set_vert(1, 24'h000000, 24'h000000, 24'h000000, 24'h000000);
    accept(2'd1);
    n = 0;
    saw_valid = 1'b0;
    while (tri_ready_o !== 1'b1 && n < 300) begin
      tick();
      n++;
      if (out_valid_o === 1'b1) saw_valid = 1'b1;
    end
    checks++; if (n != 84) begin errors++; $display("FAIL bad_ready_latency got %0d want 84", n); end
    checks++; if (saw_valid) begin errors++; $display("FAIL bad_no_output got valid 1 want 0"); end
`ifdef PERSP_VIEWPORT_STATS_EN
    checks++; if (stat_culled_o !== 32'd1) begin errors++; $display("FAIL bad_stat_culled got %0d want 1", stat_culled_o); end
    checks++; if (stat_emitted_o !== 32'd4) begin errors++; $display("FAIL bad_stat_emitted got %0d want 4", stat_emitted_o); end
`endif
  endtask

  task automatic test_mid_reset();
    int n;
    set_vp(24'h000000, 24'h000000, 24'h140000, 24'h0F0000);
    set_basic_tri(0);
    accept(2'd1);
    repeat (38) tick();
    #2 reset_i = 1'b1;
    #1;
    checks++; if (tri_ready_o !== 1'b1) begin errors++; $display("FAIL mreset_ready got %b want 1", tri_ready_o); end
    checks++; if (out_vert_o !== '0) begin errors++; $display("FAIL mreset_vert got %h want 0", out_vert_o); end
    checks++; if (out_valid_o !== 1'b0 || out_last_o !== 1'b0) begin
      errors++; $display("FAIL mreset_valid_last got %b%b want 00", out_valid_o, out_last_o); end
    reset_i = 1'b0;
    tick();
    set_vp(24'h000000, 24'h000000, 24'h140000, 24'h0F0000);
    set_basic_tri(0);
    accept(2'd1);
    wait_valid(n);
    checks++; if (n != 84) begin errors++; $display("FAIL mreset_rerun_latency got %0d want 84", n); end
    checks++; if (out_vert_o[0*W +: W] !== 24'h1E0000 || out_vert_o[7*W +: W] !== 24'h1E0000) begin
      errors++; $display("FAIL mreset_rerun_vals got %h/%h want 1e0000/1e0000",
                         out_vert_o[0*W +: W], out_vert_o[7*W +: W]); end
    handshake();
  endtask

  task automatic test_drop();
    logic [1:0] nums [2];
    nums = '{2'd0, 2'd3};
    for (int i = 0; i < 2; i++) begin
      set_basic_tri(0);
      accept(nums[i]);
      checks++; if (tri_ready_o !== 1'b0) begin errors++; $display("FAIL drop%0d_busy got %b want 0", nums[i], tri_ready_o); end
      tick();
      checks++; if (tri_ready_o !== 1'b1) begin errors++; $display("FAIL drop%0d_ready got %b want 1", nums[i], tri_ready_o); end
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL drop%0d_valid got %b want 0", nums[i], out_valid_o); end
    end
`ifdef PERSP_VIEWPORT_STATS_EN
    checks++; if (stat_culled_o !== 32'd1) begin errors++; $display("FAIL drop_stat_culled got %0d want 1", stat_culled_o); end
    checks++; if (stat_emitted_o !== 32'd1) begin errors++; $display("FAIL drop_stat_emitted got %0d want 1", stat_emitted_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_persp();
    test_back_to_back();
    test_bad_w();
    test_mid_reset();
    test_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
